// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - round-robin arbiter sharing one ALU/CAS execution controller
// One command in flight; an optional lock keeps the grant across atomic sequences.
module alu_rr_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int CMD_W        = 12,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_lock,
    input  logic [NUM_REQ*CMD_W-1:0]     req_cmd,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [31:0]                  rsp_result,
    output logic [3:0]                   rsp_flags,
    output logic                         cmd_valid,
    input  logic                         cmd_ready,
    output logic [CMD_W-1:0]             cmd_data,
    input  logic                         exe_valid,
    input  logic [31:0]                  exe_result,
    input  logic [3:0]                   exe_flags,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy,
    output logic                         lock_expired
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_LOCKED} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   grant_q;
    logic              lock_hold_q;
    logic [TMR_W-1:0]  timer_q;
    logic [CMD_W-1:0]  cmd_data_q;
    logic [31:0]       rsp_result_q;
    logic [3:0]        rsp_flags_q;

    logic              win_found;
    logic [ID_W-1:0]   win_id;
    logic [ID_W-1:0]   acc_id;
    logic              accept;
    logic              expire;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return ID_W'((int'(id) + 1) % NUM_REQ);
    endfunction

    // Descending scan so the requester closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                win_found = 1'b1;
                win_id    = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        acc_id = win_id;
        accept = 1'b0;
        expire = 1'b0;
        if (state_q == S_LOCKED) begin
            acc_id = grant_q;
            accept = req_valid[grant_q];
            expire = !req_valid[grant_q] && (timer_q == TMR_W'(LOCK_TIMEOUT - 1));
        end else if (state_q == S_IDLE) begin
            accept = win_found;
        end
        if (rst) begin
            accept = 1'b0;
            expire = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_ISSUE;
            S_ISSUE:  if (cmd_ready) state_d = S_WAIT;
            S_WAIT:   if (exe_valid) state_d = S_RESP;
            S_RESP:   state_d = lock_hold_q ? S_LOCKED : S_IDLE;
            S_LOCKED: begin
                if (accept) begin
                    state_d = S_ISSUE;
                end else if (expire) begin
                    state_d = S_IDLE;
                end
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready    = '0;
        rsp_valid    = '0;
        cmd_valid    = 1'b0;
        busy         = 1'b0;
        lock_expired = 1'b0;
        if (!rst) begin
            if (accept) begin
                req_ready[acc_id] = 1'b1;
            end
            rsp_valid[grant_q] = (state_q == S_RESP);
            cmd_valid          = (state_q == S_ISSUE);
            busy               = (state_q != S_IDLE);
            lock_expired       = expire;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            lock_hold_q  <= 1'b0;
            timer_q      <= '0;
            cmd_data_q   <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            if (accept) begin
                cmd_data_q  <= req_cmd[int'(acc_id)*CMD_W +: CMD_W];
                lock_hold_q <= req_lock[acc_id];
                grant_q     <= acc_id;
            end
            if (state_q == S_WAIT && exe_valid) begin
                rsp_result_q <= exe_result;
                rsp_flags_q  <= exe_flags;
            end
            if (state_q == S_RESP) begin
                timer_q <= '0;
                if (!lock_hold_q) begin
                    rr_ptr_q <= next_id(grant_q);
                end
            end else if (state_q == S_LOCKED && !accept) begin
                if (expire) begin
                    rr_ptr_q <= next_id(grant_q);
                end else begin
                    timer_q <= timer_q + 1'b1;
                end
            end
        end
    end

    assign cmd_data   = cmd_data_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign grant_id   = grant_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb/tb_alu_rr_arbiter.sv - scoreboard bench for alu_rr_arbiter with directed vectors
module tb_alu_rr_arbiter;
    localparam int NUM_REQ = 4;
    localparam int CMD_W   = 12;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid, req_lock, req_ready, rsp_valid;
    logic [NUM_REQ*CMD_W-1:0] req_cmd;
    logic [31:0]              rsp_result, exe_result;
    logic [3:0]               rsp_flags, exe_flags;
    logic                     cmd_valid, cmd_ready, exe_valid;
    logic [CMD_W-1:0]         cmd_data;
    logic [1:0]               grant_id;
    logic                     busy, lock_expired;

    logic                     mdl_valid, junk_valid;
    logic [31:0]              mdl_res, junk_res, ovr_res;
    logic [3:0]               mdl_flg, junk_flg, ovr_flg;
    logic                     ovr_en;
    int                       exe_delay;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic [3:0]  flg;
    } exp_t;

    exp_t        sb[$];
    logic [12:0] rq[NUM_REQ][$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    assign exe_valid  = mdl_valid | junk_valid;
    assign exe_result = junk_valid ? junk_res : mdl_res;
    assign exe_flags  = junk_valid ? junk_flg : mdl_flg;

    alu_rr_arbiter #(.NUM_REQ(NUM_REQ), .CMD_W(CMD_W), .LOCK_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_lock(req_lock), .req_cmd(req_cmd), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .exe_valid(exe_valid), .exe_result(exe_result), .exe_flags(exe_flags),
        .grant_id(grant_id), .busy(busy), .lock_expired(lock_expired)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input int id, input logic [11:0] cmd, input logic lk,
                         input logic expect_rsp, input logic [31:0] res, input logic [3:0] flg);
        exp_t e;
        rq[id].push_back({lk, cmd});
        if (expect_rsp) begin
            e.id = id; e.res = res; e.flg = flg;
            sb.push_back(e);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_result"}, rsp_result, 0);
        chk({tag, "_rsp_flags"}, rsp_flags, 0);
        chk({tag, "_cmd_valid"}, cmd_valid, 0);
        chk({tag, "_cmd_data"}, cmd_data, 0);
        chk({tag, "_grant_id"}, grant_id, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_lock_expired"}, lock_expired, 0);
    endtask

    // which: 0 = busy, 1 = cmd_valid, 2 = rsp_valid[3]; returns at the negedge where it holds
    task automatic wait_cond(input int which, input int budget, input string name);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if ((which == 0 && busy) || (which == 1 && cmd_valid) || (which == 2 && rsp_valid[3]))
                return;
        end
        total++; bad++;
        $display("FAIL %s: condition %0d not seen within %0d cycles", name, which, budget);
    endtask

    task automatic wait_done(input int budget, input string name);
        int pend;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            pend = sb.size();
            for (int i = 0; i < NUM_REQ; i++) pend += rq[i].size();
            if (pend == 0 && !busy) return;
        end
        total++; bad++;
        $display("FAIL %s: not drained within %0d cycles (sb=%0d)", name, budget, sb.size());
    endtask

    // Requesters: hold valid/cmd until accepted, then present the next queued command.
    initial begin
        logic [NUM_REQ-1:0] acc;
        req_valid = '0; req_lock = '0; req_cmd = '0;
        forever begin
            @(negedge clk);
            acc = req_ready & req_valid;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                req_valid[i] = (rq[i].size() > 0);
                req_lock[i]  = (rq[i].size() > 0) ? rq[i][0][12] : 1'b0;
                req_cmd[i*CMD_W +: CMD_W] = (rq[i].size() > 0) ? rq[i][0][11:0] : '0;
            end
        end
    end

    // Execution controller: result = A000_0000 | cmd, flags = cmd[3:0], unless overridden.
    initial begin
        logic [11:0] c;
        mdl_valid = 1'b0; mdl_res = '0; mdl_flg = '0;
        forever begin
            @(negedge clk);
            #1;
            if (cmd_valid && cmd_ready && !rst) begin
                c = cmd_data;
                repeat (exe_delay) @(negedge clk);
                @(negedge clk);
                #1;
                mdl_valid = 1'b1;
                mdl_res   = ovr_en ? ovr_res : (32'hA000_0000 | {20'h0, c});
                mdl_flg   = ovr_en ? ovr_flg : c[3:0];
                @(negedge clk);
                #1;
                mdl_valid = 1'b0;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && req_ready != 0) chk("ready_onehot", $onehot(req_ready), 1);
            if (!rst && rsp_valid != 0) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_rsp: got rsp_valid=%b expected none", rsp_valid);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", rsp_valid, 64'(4'b0001 << e.id));
                    chk("rsp_grant_id", grant_id, e.id);
                    chk("rsp_result", rsp_result, e.res);
                    chk("rsp_flags", rsp_flags, e.flg);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_ready = 1'b1; exe_delay = 1;
        junk_valid = 1'b0; junk_res = '0; junk_flg = '0;
        ovr_en = 1'b0; ovr_res = '0; ovr_flg = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");

        // Round robin 0,1,2,3,0 with everything valid; first request coincides with reset
        issue(0, 12'h100, 0, 1, 32'hA000_0100, 4'h0);
        issue(1, 12'h211, 0, 1, 32'hA000_0211, 4'h1);
        issue(2, 12'h322, 0, 1, 32'hA000_0322, 4'h2);
        issue(3, 12'h433, 0, 1, 32'hA000_0433, 4'h3);
        issue(0, 12'h104, 0, 1, 32'hA000_0104, 4'h4);
        @(negedge clk);
        chk("rst_vs_valid_ready", req_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_done(200, "t1_drain");

        // Stalled downstream: command stays put for 4 cycles, no second acceptance
        cmd_ready = 1'b0;
        issue(2, 12'hE53, 0, 1, 32'hA000_0E53, 4'h3);
        issue(2, 12'h0A5, 0, 1, 32'hA000_00A5, 4'h5);
        wait_cond(1, 20, "t2_cmd_valid");
        for (int k = 0; k < 4; k++) begin
            chk("t2_cmd_valid", cmd_valid, 1);
            chk("t2_cmd_data", cmd_data, 12'hE53);
            chk("t2_no_ready", req_ready, 0);
            if (k == 2) begin
                @(posedge clk);
                #1 cmd_ready = 1'b1;
            end
            @(negedge clk);
        end
        chk("t2_issue_done", cmd_valid, 0);
        wait_done(200, "t2_drain");

        // Lock keeps requester 1 ahead of requester 0 for the second command
        issue(1, 12'h5A1, 1, 1, 32'hA000_05A1, 4'h1);
        issue(1, 12'h312, 0, 1, 32'hA000_0312, 4'h2);
        wait_cond(0, 20, "t3_busy");
        issue(0, 12'h0C6, 0, 1, 32'hA000_00C6, 4'h6);
        wait_done(200, "t3_drain");

        // Lock timeout: requester 3 locks then goes quiet
        issue(3, 12'h7F3, 1, 1, 32'hA000_07F3, 4'h3);
        wait_cond(0, 20, "t4_busy");
        issue(0, 12'h001, 0, 1, 32'hA000_0001, 4'h1);
        issue(1, 12'h102, 0, 1, 32'hA000_0102, 4'h2);
        wait_cond(2, 40, "t4_resp");
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            chk($sformatf("t4_expired_c%0d", n), lock_expired, (n == 16));
            chk($sformatf("t4_locked_ready_c%0d", n), req_ready, 0);
        end
        @(negedge clk);
        chk("t4_expired_after", lock_expired, 0);
        chk("t4_rr_wrap_grant0", req_ready, 4'b0001);
        wait_done(200, "t4_drain");

        // Result routing, spurious exe_valid in IDLE and in ISSUE
        ovr_en = 1'b1; ovr_res = 32'h0000_0001; ovr_flg = 4'b0010;
        issue(2, 12'h0F0, 0, 1, 32'h0000_0001, 4'b0010);
        wait_done(200, "t5_drain");
        ovr_en = 1'b0;
        junk_res = 32'h1234_5678; junk_flg = 4'hF; junk_valid = 1'b1;
        @(negedge clk);
        junk_valid = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("t5_idle_rsp_valid", rsp_valid, 0);
            chk("t5_idle_result_held", rsp_result, 32'h0000_0001);
            chk("t5_idle_flags_held", rsp_flags, 4'b0010);
        end
        cmd_ready = 1'b0;
        issue(1, 12'h2B4, 0, 1, 32'hA000_02B4, 4'h4);
        wait_cond(1, 20, "t5_cmd_valid");
        junk_res = 32'hDEAD_BEEF; junk_flg = 4'hF; junk_valid = 1'b1; cmd_ready = 1'b1;
        @(negedge clk);
        junk_valid = 1'b0;
        wait_done(200, "t5b_drain");

        // Reset during WAIT discards the in-flight result and restarts rr at 0
        exe_delay = 3;
        issue(2, 12'h6C6, 0, 0, 32'h0, 4'h0);
        wait_cond(1, 20, "t6_cmd_valid");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("t6_reset");
        rst = 1'b0;
        repeat (8) @(negedge clk);
        exe_delay = 1;
        issue(0, 12'h3C0, 0, 1, 32'hA000_03C0, 4'h0);
        issue(3, 12'h4E7, 0, 1, 32'hA000_04E7, 4'h7);
        wait_done(200, "t6_drain");

        repeat (4) @(negedge clk);
        chk("final_sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
